pcie_tx_block_feeder: RTL

PCIE_TX_BLOCK_FEEDER -- requirements
Module: pcie_tx_block_feeder

---
 rtl/pcie_phy_pkg.sv | 15 +
 rtl/pcie_tx_blk_fifo.sv | 49 ++++
 rtl/pcie_tx_block_feeder.sv | 114 +++++++++++
 3 files changed

// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared constants and types for the PCIe TX PHY blocks
package pcie_phy_pkg;

  localparam int PAYLOAD_W_DEFAULT = 128;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/pcie_tx_blk_fifo.sv
// rtl/pcie_tx_blk_fifo.sv - two-entry block FIFO with registered occupancy count
module pcie_tx_blk_fifo #(
  parameter int WIDTH = 129
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Requests that would overflow or underflow are ignored.
  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_tx_block_feeder.sv
// rtl/pcie_tx_block_feeder.sv - feeds sync-headed 130-bit blocks to the TX serializer
module pcie_tx_block_feeder
  import pcie_phy_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEFAULT,
  parameter int BLOCK_W   = PAYLOAD_W + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [PAYLOAD_W-1:0] s_data,
  input  logic                 s_os,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [BLOCK_W-1:0]   blk_data,
  output logic                 blk_load,
  output logic [7:0]           blk_cnt,
  output logic                 idle_inserted,
  output logic [15:0]          underrun_cnt
);

  localparam logic [7:0]         CNT_LAST   = 8'(BLOCK_W - 1);
  localparam logic [BLOCK_W-1:0] IDLE_BLOCK = {SYNC_DATA, {PAYLOAD_W{1'b0}}};

  feeder_state_t      state;
  feeder_state_t      state_next;
  logic               load;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [1:0]         fifo_count;
  logic [PAYLOAD_W:0] fifo_head;

  // Ready depends only on the registered count, so a pop never opens a full FIFO early.
  assign s_ready    = (fifo_count < 2'd2);
  assign push       = s_valid && s_ready;
  assign fifo_empty = (fifo_count == 2'd0);
  assign pop        = load && !fifo_empty;

  pcie_tx_blk_fifo #(
    .WIDTH(PAYLOAD_W + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({s_os, s_data}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_OFF;
    end else begin
      state <= state_next;
    end
  end

  // Next state and load decision; a load lands on every edge that makes blk_cnt 0 in RUN.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_OFF: begin
        if (en) state_next = ST_PRIME;
      end
      ST_PRIME: begin
        if (en) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end else begin
          state_next = ST_OFF;
        end
      end
      ST_RUN: begin
        if (blk_cnt == CNT_LAST) begin
          if (en) load = 1'b1;
          else    state_next = ST_OFF;
        end
      end
      default: state_next = ST_OFF;
    endcase
  end

  // Bit-time counter, registered block output, pulses and underrun statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt       <= 8'd0;
      blk_data      <= '0;
      blk_load      <= 1'b0;
      idle_inserted <= 1'b0;
      underrun_cnt  <= 16'd0;
    end else begin
      blk_load      <= load;
      idle_inserted <= load && fifo_empty;
      if (state == ST_RUN && blk_cnt != CNT_LAST) begin
        blk_cnt <= blk_cnt + 8'd1;
      end else begin
        blk_cnt <= 8'd0;
      end
      if (load) begin
        if (fifo_empty) begin
          blk_data <= IDLE_BLOCK;
          if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end else begin
          blk_data <= {(fifo_head[PAYLOAD_W] ? SYNC_OS : SYNC_DATA), fifo_head[PAYLOAD_W-1:0]};
        end
      end
    end
  end

endmodule
